// File: rtl/bcd_pkg.sv
// Shared types and glyph table for the calculator display front end.
// Segment encodings are active-low, bit order {g,f,e,d,c,b,a}.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, // 0
    7'h79, // 1
    7'h24, // 2
    7'h30, // 3
    7'h19, // 4
    7'h12, // 5
    7'h02, // 6
    7'h78, // 7
    7'h00, // 8
    7'h10  // 9
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-7-segment decoder, active-low outputs.
// Non-decimal nibbles and the blank request both produce an unlit digit.
module seg7_decoder
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    if (!blank) begin
      for (int i = 0; i < 10; i++) begin
        if (bcd == i[3:0]) seg_n = SEG_DIGIT[i];
      end
    end
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display front end: iterative double-dabble plus a free-running
// common-anode digit scanner. Define LZ_BLANK_EN to blank leading zero digits.
//
// Handshake: a transfer happens on a rising clk edge where in_valid && in_ready;
// in_ready is a registered output, high only while the converter is idle, and
// in_valid/in_bin are ignored on any edge where in_ready is low.
module bcd_display_ctrl
  import bcd_pkg::*;
#(
  parameter int BIN_W       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic [DIGITS-1:0]     an_n,
  output logic [6:0]            seg_n
);

  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int SCAN_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("bcd_display_ctrl: REFRESH_DIV must be >= 2");
  end
  if (10**DIGITS <= 2**BIN_W - 1) begin : g_bad_digits
    $error("bcd_display_ctrl: DIGITS too small for BIN_W");
  end

  // ---------------------------------------------------------------------------
  // Converter FSM (state is observable hierarchically as 'state')
  // ---------------------------------------------------------------------------
  state_t                state;
  logic [BIN_W-1:0]      bin_r;
  logic [4*DIGITS-1:0]   work;
  logic [4*DIGITS-1:0]   work_adj;
  logic [CNT_W-1:0]      cnt;

  always_comb begin
    work_adj = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5) work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      bin_r     <= '0;
      work      <= '0;
      cnt       <= '0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            bin_r    <= in_bin;
            work     <= '0;
            cnt      <= CNT_W'(BIN_W);
            state    <= CONV;
            in_ready <= 1'b0;
          end
        end
        CONV: begin
          // Adjust then shift the combined {work,bin} register left by one.
          work  <= {work_adj[4*DIGITS-2:0], bin_r[BIN_W-1]};
          bin_r <= bin_r << 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= COMMIT;
        end
        COMMIT: begin
          bcd_out   <= work;
          bcd_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scanner
  // ---------------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic [6:0]        seg_dec;

  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == k[IDX_W-1:0]) cur_digit = bcd_out[4*k +: 4];
    end
  end

`ifdef LZ_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic              zeros_above;

  // lz[k] is set when digit k and every more significant digit are zero.
  always_comb begin
    lz          = '0;
    zeros_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zeros_above = zeros_above && (bcd_out[4*k +: 4] == 4'd0);
      lz[k]       = zeros_above;
    end
  end

  always_comb begin
    cur_blank = 1'b0;
    for (int k = 1; k < DIGITS; k++) begin
      if (idx == k[IDX_W-1:0]) cur_blank = lz[k];
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  seg7_decoder u_dec (
    .bcd   (cur_digit),
    .blank (cur_blank),
    .seg_n (seg_dec)
  );

  // an_n and seg_n are both registered from the same idx so they stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      an_n     <= '1;
      seg_n    <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
        scan_cnt <= '0;
        if (idx == IDX_W'(DIGITS - 1)) idx <= '0;
        else                           idx <= idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an_n  <= ~(DIGITS'(1) << idx);
      seg_n <= seg_dec;
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl with REFRESH_DIV=4; glyph expectations
// follow LZ_BLANK_EN when it is defined for the build.
module tb_bcd_display_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_bin;
  logic [11:0] bcd_out;
  logic        bcd_valid;
  logic [2:0]  an_n;
  logic [6:0]  seg_n;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int valid_cnt   = 0;

  logic [11:0] exp_q[$];

  bcd_display_ctrl #(
    .BIN_W       (8),
    .DIGITS      (3),
    .REFRESH_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .an_n      (an_n),
    .seg_n     (seg_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; every bcd_valid pulse is scored against the expected queue.
  task automatic step();
    logic [11:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (bcd_valid === 1'b1) begin
      valid_cnt++;
      chk("valid_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("bcd_out", bcd_out, e);
      end
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic accept(input logic [7:0] v, input logic [11:0] e);
    int lat;
    int vc0;
    bit ready_ok;
    wait_ready();
    in_valid = 1'b1;
    in_bin   = v;
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
    lat      = 0;
    vc0      = valid_cnt;
    ready_ok = 1'b1;
    while (valid_cnt == vc0 && lat < 20) begin
      step();
      lat++;
      if (bcd_valid !== 1'b1 && in_ready !== 1'b0) ready_ok = 1'b0;
    end
    chk("latency", lat, 9);
    chk("ready_low_in_conv", ready_ok, 1);
    step();
    chk("valid_one_cycle", bcd_valid, 0);
  endtask

  // Watch one full scan period and check the glyph shown under each anode.
  task automatic check_display(input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    logic [2:0] seen;
    seen = 3'b000;
    repeat (12) begin
      step();
      case (an_n)
        3'b110: begin seen[0] = 1'b1; chk("seg_d0", seg_n, e0); end
        3'b101: begin seen[1] = 1'b1; chk("seg_d1", seg_n, e1); end
        3'b011: begin seen[2] = 1'b1; chk("seg_d2", seg_n, e2); end
        default: chk("an_onehot", an_n, 3'b110);
      endcase
    end
    chk("scan_all_digits", seen, 3'b111);
  endtask

  initial begin
    int acc;
    int acc2_cyc;
    int v1_cyc;
    int vc0;
    int n;
    bit pre;
    logic [2:0] prev_an;
    logic [2:0] exp_an;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bin   = 8'd0;

    // 1: reset values
    step();
    step();
    chk("rst_an_n", an_n, 3'b111);
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_bcd_out", bcd_out, 12'h000);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bcd_valid", bcd_valid, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", in_ready, 1);
    chk("an_after_release", an_n, 3'b110);

    // 2: full-scale value
    accept(8'd255, 12'h255);
    step();
    check_display(7'h24, 7'h12, 7'h12);

    // 3: zero, leading-zero handling
    accept(8'd0, 12'h000);
    step();
`ifdef LZ_BLANK_EN
    check_display(7'h7F, 7'h7F, 7'h40);
`else
    check_display(7'h40, 7'h40, 7'h40);
`endif

    // 4: back-to-back with in_valid held high
    wait_ready();
    in_valid = 1'b1;
    in_bin   = 8'd99;
    exp_q.push_back(12'h099);
    acc      = 0;
    acc2_cyc = -1;
    v1_cyc   = -1;
    vc0      = valid_cnt;
    n        = 0;
    while ((valid_cnt - vc0) < 2 && n < 40) begin
      pre = in_valid && in_ready;
      step();
      n++;
      if (pre) begin
        acc++;
        if (acc == 1) begin
          in_bin = 8'd100;
          exp_q.push_back(12'h100);
        end else if (acc == 2) begin
          acc2_cyc = cyc;
          in_valid = 1'b0;
        end
      end
      if (bcd_valid === 1'b1 && (valid_cnt - vc0) == 1) v1_cyc = cyc;
    end
    chk("b2b_accepts", acc, 2);
    chk("b2b_valids", valid_cnt - vc0, 2);
    chk("b2b_second_after_first", acc2_cyc, v1_cyc + 1);
    chk("b2b_queue_empty", exp_q.size(), 0);
    step();
    check_display(7'h79, 7'h40, 7'h40);

    // 5: reset during conversion
    wait_ready();
    in_valid = 1'b1;
    in_bin   = 8'd200;
    exp_q.push_back(12'h200);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    exp_q.delete();
    rst_n = 1'b0;
    vc0   = valid_cnt;
    step();
    step();
    chk("abort_bcd_out", bcd_out, 12'h000);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_an_n", an_n, 3'b111);
    chk("abort_seg_n", seg_n, 7'h7F);
    rst_n = 1'b1;
    step();
    chk("abort_ready_release", in_ready, 1);
    repeat (12) step();
    chk("abort_no_valid", valid_cnt, vc0);
    chk("abort_bcd_hold", bcd_out, 12'h000);
    accept(8'd7, 12'h007);
    step();
`ifdef LZ_BLANK_EN
    check_display(7'h7F, 7'h7F, 7'h78);
`else
    check_display(7'h40, 7'h40, 7'h78);
`endif

    // 6: idle scan order and dwell
    n = 0;
    prev_an = an_n;
    step();
    while (!(an_n == 3'b110 && prev_an != 3'b110) && n < 20) begin
      prev_an = an_n;
      step();
      n++;
    end
    chk("scan_align", an_n, 3'b110);
    for (int i = 1; i < 16; i++) begin
      step();
      case (i / 4)
        0:       exp_an = 3'b110;
        1:       exp_an = 3'b101;
        2:       exp_an = 3'b011;
        default: exp_an = 3'b110;
      endcase
      chk("scan_seq", an_n, exp_an);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
